// File: rtl/dmem_pkg.sv
// Shared types and defaults for the MEM-stage data-memory controller.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  localparam int unsigned       TIMEOUT_DEF  = 64;
  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/acknowledge port between the MEM-stage controller and data memory.
interface dmem_ctrl_if;
  import dmem_pkg::*;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/dmem_timeout_ctr.sv
// Counts WAIT cycles; expired flags the last cycle allowed without an ack.
module dmem_timeout_ctr
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: turns EX/MEM load/store controls into a
// req/ack transaction and stalls the front of the pipeline until it completes.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  dmem_ctrl_if.master       mem,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  dmem_state_e       state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              expired;

  dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (state_q != WAIT),
    .en      (state_q == WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next state and next register values; a write wins when both controls are set.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    stall_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (MemRead_i || MemWrite_i) begin
          stall_o = 1'b1;
          req_d   = 1'b1;
          we_d    = MemWrite_i;
          addr_d  = addr_i & ~DATA_W'(3);
          wdata_d = wdata_i;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (mem.mem_ack_i) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) rdata_d = mem.mem_rdata_i;
        end else if (expired) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) rdata_d = ERR_DATA;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign rdata_o         = rdata_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance with the default timeout, one with TIMEOUT=4.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int unsigned T_A = 64;
  localparam int unsigned T_B = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        rd, wr, ack;
  logic [31:0] addr, wdata, mrdata;

  logic        stall_a, stall_b, err_a, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic        stall_s, err_s, req_s, we_s;
  logic [31:0] rdata_s, addr_s, wdata_s;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rexp [2];

  always #5 clk = ~clk;

  dmem_ctrl_if mem_a ();
  dmem_ctrl_if mem_b ();

  assign mem_a.mem_ack_i   = ack & ~sel;
  assign mem_a.mem_rdata_i = mrdata;
  assign mem_b.mem_ack_i   = ack & sel;
  assign mem_b.mem_rdata_i = mrdata;

  dmem_ctrl #(.TIMEOUT(T_A)) u_dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .MemRead_i  (rd & ~sel),
    .MemWrite_i (wr & ~sel),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .mem        (mem_a),
    .stall_o    (stall_a),
    .rdata_o    (rdata_a),
    .err_o      (err_a)
  );

  dmem_ctrl #(.TIMEOUT(T_B)) u_dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .MemRead_i  (rd & sel),
    .MemWrite_i (wr & sel),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .mem        (mem_b),
    .stall_o    (stall_b),
    .rdata_o    (rdata_b),
    .err_o      (err_b)
  );

  assign stall_s = sel ? stall_b : stall_a;
  assign err_s   = sel ? err_b : err_a;
  assign rdata_s = sel ? rdata_b : rdata_a;
  assign req_s   = sel ? mem_b.mem_req_o : mem_a.mem_req_o;
  assign we_s    = sel ? mem_b.mem_we_o : mem_a.mem_we_o;
  assign addr_s  = sel ? mem_b.mem_addr_o : mem_a.mem_addr_o;
  assign wdata_s = sel ? mem_b.mem_wdata_o : mem_a.mem_wdata_o;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req"}, 32'(req_s), 32'd0);
    check_eq({tag, "_we"}, 32'(we_s), 32'd0);
    check_eq({tag, "_addr"}, addr_s, 32'd0);
    check_eq({tag, "_wdata"}, wdata_s, 32'd0);
    check_eq({tag, "_rdata"}, rdata_s, 32'd0);
    check_eq({tag, "_err"}, 32'(err_s), 32'd0);
  endtask

  // Non-memory cycles with random spurious acks: nothing may move.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd = 1'b0; wr = 1'b0; addr = $urandom; wdata = $urandom;
      ack = 1'($urandom_range(0, 1)); mrdata = $urandom;
      #1;
      check_eq("idle_stall", 32'(stall_s), 32'd0);
      check_eq("idle_req", 32'(req_s), 32'd0);
      check_eq("idle_rdata", rdata_s, rexp[sel]);
      check_eq("idle_err", 32'(err_s), 32'd0);
    end
  endtask

  // One transaction; k is the ack delay in cycles after the access appears.
  task automatic do_access(input logic s, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] mem_val, input int k, input bit late_ack);
    int  t;
    bit  tmo;
    int  exp_stalls;
    bit  done;
    t          = s ? int'(T_B) : int'(T_A);
    tmo        = (k > t);
    exp_stalls = (tmo ? t : k) + 1;
    done       = 1'b0;

    @(negedge clk);
    sel = s; rd = r; wr = w; addr = a; wdata = wd; ack = 1'b0; mrdata = $urandom;
    #1;
    check_eq("first_stall", 32'(stall_s), 32'd1);
    check_eq("first_req", 32'(req_s), 32'd0);
    check_eq("err_pulse_end", 32'(err_s), 32'd0);

    for (int c = 1; c <= t + 4 && !done; c++) begin
      @(negedge clk);
      ack    = (c == k) || (late_ack && tmo && c == t + 1);
      mrdata = (c == k) ? mem_val : $urandom;
      #1;
      if (!stall_s) begin
        done = 1'b1;
        if (!w) rexp[s] = tmo ? ERR_DATA_DEF : mem_val;
        check_eq("stall_cycles", 32'(c), 32'(exp_stalls));
        check_eq("done_rdata", rdata_s, rexp[s]);
        check_eq("done_err", 32'(err_s), 32'(tmo));
        check_eq("done_req", 32'(req_s), 32'd0);
      end else begin
        check_eq("wait_req", 32'(req_s), 32'd1);
        check_eq("wait_addr", addr_s, {a[31:2], 2'b00});
        check_eq("wait_we", 32'(we_s), 32'(w));
        check_eq("wait_wdata", wdata_s, wd);
      end
    end
    check_eq("done_seen", 32'(done), 32'd1);

    if (late_ack) begin
      @(negedge clk);
      rd = 1'b0; wr = 1'b0; ack = 1'b1; mrdata = $urandom;
      #1;
      check_eq("late_ack_stall", 32'(stall_s), 32'd0);
      check_eq("late_ack_req", 32'(req_s), 32'd0);
      check_eq("late_ack_rdata", rdata_s, rexp[s]);
      check_eq("late_ack_err", 32'(err_s), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0; ack = 1'b0;
    addr = '0; wdata = '0; mrdata = '0;
    rexp[0] = '0; rexp[1] = '0;

    #12;
    check_reset_vals("rst_a");
    check_eq("rst_a_stall", 32'(stall_s), 32'd0);
    sel = 1'b1; #1;
    check_reset_vals("rst_b");
    rd = 1'b1; #1;
    check_eq("rst_b_stall_idle_rule", 32'(stall_s), 32'd1);
    rd = 1'b0; sel = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Load latency 1, store latency 5, timeout with a late ack.
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_0104, $urandom, 32'h1234_5678, 1, 1'b0);
    idle_cycles(3);
    do_access(1'b0, 1'b0, 1'b1, 32'h0000_0207, 32'hCAFE_F00D, $urandom, 5, 1'b0);
    idle_cycles(2);
    do_access(1'b1, 1'b1, 1'b0, 32'h0000_0300, $urandom, 32'h0000_0055, 99, 1'b1);
    idle_cycles(1);

    // Back-to-back load, store, then both controls high.
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_1000, $urandom, 32'hA5A5_0001, 2, 1'b0);
    do_access(1'b0, 1'b0, 1'b1, 32'h0000_1004, 32'h1111_2222, $urandom, 3, 1'b0);
    do_access(1'b0, 1'b1, 1'b1, 32'h0000_100B, 32'h3333_4444, 32'h5555_6666, 2, 1'b0);
    idle_cycles(1);

    // Reset while waiting for an ack.
    @(negedge clk);
    sel = 1'b0; rd = 1'b1; wr = 1'b0; addr = 32'h0000_0ABC; ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_wait_pre_req", 32'(req_s), 32'd1);
    @(negedge clk);
    rst = 1'b1; ack = 1'b1; mrdata = 32'h0BAD_0BAD;
    #1;
    check_reset_vals("rst_wait");
    check_eq("rst_wait_stall", 32'(stall_s), 32'd1);
    @(negedge clk); rd = 1'b0;
    #1;
    check_eq("rst_wait_stall_off", 32'(stall_s), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check_reset_vals("rst_after_ack");
    check_eq("rst_after_stall", 32'(stall_s), 32'd0);
    ack = 1'b0;
    rexp[0] = '0; rexp[1] = '0;

    // Randomized transactions on both instances.
    for (int i = 0; i < 80; i++) begin
      logic s;
      int   kind, t, k;
      s    = ($urandom_range(0, 3) == 0);
      kind = $urandom_range(0, 2);
      t    = s ? int'(T_B) : int'(T_A);
      if ($urandom_range(0, 9) == 0) k = t + $urandom_range(0, 2);
      else                           k = $urandom_range(1, s ? 4 : 8);
      do_access(s, kind != 1, kind != 0, $urandom, $urandom, $urandom, k,
                1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

MEM-stage data-memory controller sitting directly downstream of the EX/MEM pipeline register. It turns the registered MemRead/MemWrite controls, address and store data into a request/acknowledge transaction on a variable-latency data-memory port. It raises a stall to freeze the front of the pipeline until the access completes, then presents load data to the MEM/WB register.

## Interface
- `TIMEOUT`, default 64: maximum WAIT cycles without `mem_ack_i` before forced completion; range 2..255.
- `ERR_DATA`, default 32'hDEADBEEF: load data returned on timeout.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `MemRead_i` in 1: load request from the EX/MEM register.
- `MemWrite_i` in 1: store request from the EX/MEM register.
- `addr_i` in 32: byte address (EX/MEM ALU result); bits [1:0] ignored, word access only.
- `wdata_i` in 32: store data (EX/MEM write data).
- `mem_req_o` out 1: request to data memory, registered.
- `mem_we_o` out 1: 1 = write, 0 = read; valid while `mem_req_o`.
- `mem_addr_o` out 32: word-aligned address ({addr[31:2],2'b00}), registered.
- `mem_wdata_o` out 32: store data, registered.
- `mem_ack_i` in 1: single-cycle completion from memory.
- `mem_rdata_i` in 32: read data, valid with `mem_ack_i`.
- `stall_o` out 1: freezes PC, IF/ID, ID/EX and EX/MEM.
- `rdata_o` out 32: load data to MEM/WB, registered.
- `err_o` out 1: one-cycle pulse on timeout completion.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: an access is present when `MemRead_i | MemWrite_i`. If present, `stall_o`=1 (combinational) and the controller latches the address, data, and `mem_we_o`=`MemWrite_i`. It sets `mem_req_o`=1 and moves to WAIT. If absent, `stall_o`=0 and nothing changes.
- Both `MemRead_i` and `MemWrite_i` high: treated as a write, and `rdata_o` is not updated.
- WAIT: `stall_o`=1, and `mem_req_o`, `mem_addr_o`, `mem_wdata_o` and `mem_we_o` stay stable.
  - On `mem_ack_i`: clear `mem_req_o`. On a read, load `rdata_o`←`mem_rdata_i`. Go to DONE.
  - On timeout: the timeout counter starts at 0 on entry to WAIT and increments each WAIT cycle. When it reaches `TIMEOUT-1` with no ack, clear `mem_req_o`, load `rdata_o`←`ERR_DATA` on a read, pulse `err_o`, and go to DONE.
- DONE: `stall_o`=0 for exactly one cycle, so the pipeline advances and MEM/WB captures `rdata_o`. The next state is always IDLE, and the new EX/MEM contents are evaluated there.
- `mem_ack_i` outside WAIT is ignored (late or spurious ack).
- `rdata_o` holds its value across non-load cycles and writes.

## Timing
- Reset values (asynchronous, while `rst_i`=1): state=IDLE, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `rdata_o`=0, `err_o`=0, counter=0. `stall_o` follows the IDLE rule.
- Access first visible in cycle N. Cycles N and N+1 onward have `stall_o`=1, and `mem_req_o` rises at the N→N+1 edge.
- Ack in cycle N+k (k≥1) gives DONE in cycle N+k+1. `rdata_o` is valid from that cycle, `stall_o`=0, and the minimum is 2 stall cycles.
- Timeout gives DONE in cycle N+TIMEOUT+1, with `err_o`=1 in that cycle only.
- Back-to-back accesses use IDLE→WAIT→DONE→IDLE, with one non-stalled cycle between them.
- Reset in WAIT: `mem_req_o` drops immediately, and any ack after reset is ignored.

## Structure
- Shared package `dmem_pkg`: state enum (IDLE/WAIT/DONE), default `TIMEOUT`, `ERR_DATA`.
- Sub-module `dmem_timeout_ctr`: 8-bit counter with clear/enable, and an `expired` output at `TIMEOUT-1`.
- Remaining logic is the FSM, the request latches and the `rdata_o` register in `dmem_ctrl`.

## Test plan
- Load, ack latency 1: `MemRead_i`=1, `addr_i`=32'h0000_0104, ack with `mem_rdata_i`=32'h1234_5678 in cycle N+1.
  - `mem_addr_o`=32'h104, `mem_we_o`=0, and `stall_o`=1 in cycles N and N+1.
  - DONE at N+2 with `rdata_o`=32'h1234_5678 and `stall_o`=0.
- Store, latency 5: `MemWrite_i`=1, `addr_i`=32'h0000_0207, `wdata_i`=32'hCAFE_F00D.
  - `mem_addr_o`=32'h204, `mem_we_o`=1, and the request fields stay stable for 5 cycles.
  - `rdata_o` is unchanged, and `stall_o` is high for 6 cycles.
- Timeout with `TIMEOUT`=4 and no ack: after 4 WAIT cycles, `rdata_o`=32'hDEADBEEF and a single `err_o` pulse. An ack arriving after timeout is ignored.
- Non-memory instruction (both controls 0): `stall_o`=0 throughout, no request, `rdata_o` holds its previous value.
- Back-to-back: a load then a store in consecutive EX/MEM slots gives two full transactions with exactly one `stall_o`=0 cycle between them. Both controls high behaves as a store.
- Reset asserted mid-WAIT: `mem_req_o`=0 and state IDLE immediately. An ack during or after reset has no effect, and all outputs take their reset values.
